mac_dot_seq: RTL and testbench

Dot-product sequencer that sits directly upstream of the combinational `mac` block and also consumes its result. It accepts a stream of 16-bit operand pairs over a valid/ready handshake and drives the `mac` A/B/C inputs from registers. It accumulates each returned 32-bit `R` into a wide accumulator and emits one dot-product result per `VEC_LEN` pairs on a valid/ready output.

---
 rtl/mac_dot_seq.sv | 122 ++++++++++++
 tb/tb_mac_dot_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: registers operand pairs into an external combinational
// mac stage and accumulates its 32-bit results into one result per VEC_LEN pairs.
module mac_dot_seq #(
  parameter int unsigned VEC_LEN = 8,
  parameter int unsigned ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      bias,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [15:0]      mac_c,
  input  logic [31:0]      mac_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {INIT, RUN, FLUSH, DONE} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [15:0]      a_q, b_q, c_q;
  logic [IDX_W-1:0] idx_q;
  logic             sv_q;
  logic             first_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             hs;
  logic [ACC_W:0]   sum;

  always_comb begin
    hs    = in_valid & in_ready_q;
    sum   = {1'b0, acc_q} + (ACC_W + 1)'(mac_r);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (sv_q) begin
      if (first_q) begin
        acc_d = ACC_W'(mac_r);
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        ovf_d = ovf_q | sum[ACC_W];
      end
    end
  end

  // The final accumulate happens on the FLUSH->DONE edge, so acc_q is already
  // settled when out_valid rises and stays put through DONE (sv_q is 0 there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      idx_q       <= '0;
      sv_q        <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      sv_q  <= hs;
      if (hs) begin
        a_q     <= in_a;
        b_q     <= in_b;
        c_q     <= (idx_q == '0) ? bias : '0;
        first_q <= (idx_q == '0);
        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      case (state_q)
        INIT: begin
          state_q    <= RUN;
          in_ready_q <= 1'b1;
        end
        RUN: begin
          if (hs && (idx_q == IDX_LAST)) begin
            state_q    <= FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= INIT;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign mac_c     = c_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with an exact mac model (R = A*B + C).
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        v1_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0, bias = '0;

  logic        rdy40, ov40, ovf40;
  logic [15:0] ma40, mb40, mc40;
  logic [31:0] r40;
  logic [39:0] d40;

  logic        rdy32, ov32, ovf32;
  logic [15:0] ma32, mb32, mc32;
  logic [31:0] r32;
  logic [31:0] d32;

  logic        rdy1, ov1, ovf1;
  logic [15:0] ma1, mb1, mc1;
  logic [31:0] r1;
  logic [39:0] d1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign r40 = {16'b0, ma40} * {16'b0, mb40} + {16'b0, mc40};
  assign r32 = {16'b0, ma32} * {16'b0, mb32} + {16'b0, mc32};
  assign r1  = {16'b0, ma1}  * {16'b0, mb1}  + {16'b0, mc1};

  mac_dot_seq #(.VEC_LEN(4), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy40),
    .in_a(in_a), .in_b(in_b), .bias(bias),
    .mac_a(ma40), .mac_b(mb40), .mac_c(mc40), .mac_r(r40),
    .out_valid(ov40), .out_ready(out_ready), .out_data(d40), .out_ovf(ovf40)
  );

  mac_dot_seq #(.VEC_LEN(4), .ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(in_a), .in_b(in_b), .bias(bias),
    .mac_a(ma32), .mac_b(mb32), .mac_c(mc32), .mac_r(r32),
    .out_valid(ov32), .out_ready(out_ready), .out_data(d32), .out_ovf(ovf32)
  );

  mac_dot_seq #(.VEC_LEN(1), .ACC_W(40)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .bias(bias),
    .mac_a(ma1), .mac_b(mb1), .mac_c(mc1), .mac_r(r1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_ovf(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] bs);
    int t = 0;
    in_a = a; in_b = b; bias = bs; in_valid = 1'b1;
    while (!rdy40 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 40) check("send_ready", {63'b0, rdy40}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] av, input logic [63:0] bv,
                          input logic [15:0] bs, input int gap);
    for (int i = 0; i < 4; i++) begin
      send(av[16*i +: 16], bv[16*i +: 16], bs);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  // Called #1 after the last accept with out_ready=1; reports when out_valid
  // was first seen (sample index) and how many samples had in_ready low.
  task automatic collect(output logic [39:0] d, output logic o,
                         output logic [31:0] dd32, output logic o32,
                         output int gap, output int vat);
    gap = 0; vat = -1; d = '0; o = 1'b0; dd32 = '0; o32 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (rdy40) break;
      gap++;
      if (ov40 && vat < 0) begin
        vat = t; d = d40; o = ovf40; dd32 = d32; o32 = ovf32;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [39:0] rd;
  logic        ro, ro32;
  logic [31:0] rd32;
  int          gp, va;

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", {63'b0, rdy40}, 64'd0);
    check("rst_out_valid", {63'b0, ov40}, 64'd0);
    check("rst_out_data", {24'b0, d40}, 64'd0);
    check("rst_out_ovf", {63'b0, ovf40}, 64'd0);
    check("rst_mac_abc", {16'b0, ma40, mb40, mc40}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", {63'b0, rdy40}, 64'd1);

    // Case 1: basic vector
    out_ready = 1'b1;
    send_vec({16'd7, 16'd5, 16'd3, 16'd1}, {16'd8, 16'd6, 16'd4, 16'd2}, 16'd10, 0);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c1_data", {24'b0, rd}, 64'd110);
    check("c1_ovf", {63'b0, ro}, 64'd0);
    check("c1_valid_edge", 64'(va), 64'd1);
    check("c1_ready_gap", 64'(gp), 64'd2);

    // Case 2: back-pressure
    out_ready = 1'b0;
    send_vec({16'd7, 16'd5, 16'd3, 16'd1}, {16'd8, 16'd6, 16'd4, 16'd2}, 16'd10, 0);
    check("c2_valid_early", {63'b0, ov40}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("c2_valid_hold", {63'b0, ov40}, 64'd1);
      check("c2_data_hold", {24'b0, d40}, 64'd110);
      check("c2_ready_low", {63'b0, rdy40}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("c2_valid_drop", {63'b0, ov40}, 64'd0);
    check("c2_ready_back", {63'b0, rdy40}, 64'd1);

    // Case 3: overflow
    send_vec({16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, 16'd0, 0);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c3_data32", {32'b0, rd32}, 64'hFFFC0002);
    check("c3_ovf32", {63'b0, ro32}, 64'd1);
    check("c3_data40", {24'b0, rd}, 64'h1FFFC0002);
    check("c3_ovf40", {63'b0, ro}, 64'd0);
    send_vec({16'd1, 16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1}, 16'd0, 0);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c3_next_data32", {32'b0, rd32}, 64'd4);
    check("c3_next_ovf32", {63'b0, ro32}, 64'd0);

    // Case 4: input gaps
    send_vec({16'd7, 16'd5, 16'd3, 16'd1}, {16'd8, 16'd6, 16'd4, 16'd2}, 16'd10, 3);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c4_data", {24'b0, rd}, 64'd110);
    check("c4_valid_edge", 64'(va), 64'd1);

    // Case 5: reset mid-vector
    send(16'd1, 16'd2, 16'd10);
    send(16'd3, 16'd4, 16'd10);
    rst_n = 1'b0;
    #1;
    check("c5_rst_valid", {63'b0, ov40}, 64'd0);
    check("c5_rst_ready", {63'b0, rdy40}, 64'd0);
    check("c5_rst_mac_a", {48'b0, ma40}, 64'd0);
    @(posedge clk); #1;
    check("c5_rst_ready_hold", {63'b0, rdy40}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("c5_release_ready", {63'b0, rdy40}, 64'd1);
    send_vec({16'd7, 16'd5, 16'd3, 16'd1}, {16'd8, 16'd6, 16'd4, 16'd2}, 16'd10, 0);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c5_data", {24'b0, rd}, 64'd110);

    // Case 6: back-to-back vectors
    send_vec({16'd7, 16'd5, 16'd3, 16'd1}, {16'd8, 16'd6, 16'd4, 16'd2}, 16'd10, 0);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c6_data_a", {24'b0, rd}, 64'd110);
    check("c6_gap", 64'(gp), 64'd2);
    send_vec({16'd2, 16'd2, 16'd2, 16'd2}, {16'd2, 16'd2, 16'd2, 16'd2}, 16'd0, 0);
    collect(rd, ro, rd32, ro32, gp, va);
    check("c6_data_b", {24'b0, rd}, 64'd16);
    check("c6_ovf_b", {63'b0, ro}, 64'd0);

    // VEC_LEN=1: every pair is its own vector, bias included each time
    in_a = 16'd300; in_b = 16'd200; bias = 16'd7; v1_valid = 1'b1;
    check("v1_ready", {63'b0, rdy1}, 64'd1);
    @(posedge clk); #1;
    v1_valid = 1'b0;
    check("v1_valid_early", {63'b0, ov1}, 64'd0);
    @(posedge clk); #1;
    check("v1_valid", {63'b0, ov1}, 64'd1);
    check("v1_data", {24'b0, d1}, 64'd60007);
    @(posedge clk); #1;
    check("v1_ready_back", {63'b0, rdy1}, 64'd1);
    in_a = 16'hFFFF; in_b = 16'hFFFF; bias = 16'hFFFF; v1_valid = 1'b1;
    @(posedge clk); #1;
    v1_valid = 1'b0;
    @(posedge clk); #1;
    check("v1_data_max", {24'b0, d1}, 64'hFFFF0000);
    check("v1_ovf_max", {63'b0, ovf1}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
